// File: rtl/wr_arb_pkg.sv
// Shared types and default constants for the two-requester write-port arbiter.
package wr_arb_pkg;

   typedef enum logic [1:0] {IDLE, GRANT, ACK} arb_state_t;

   localparam int unsigned WAIT_MAX_DEF = 8;
   localparam int unsigned SEL_BIT_DEF  = 11;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the requester other than
// the last winner is chosen.
module rr_pick2 (
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic grant_valid,
   output logic grant_id
);

   always_comb begin
      grant_valid = req0 | req1;
      if (req0 && req1) begin
         grant_id = ~last;
      end else begin
         grant_id = req1;
      end
   end

endmodule

// File: rtl/wr_port_arbiter.sv
// Shares one write port between the CPU store path (0) and the loader/debug
// path (1): grant, wait for target ready (with timeout), then a one-cycle ack.
module wr_port_arbiter
   import wr_arb_pkg::*;
#(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned SEL_BIT  = SEL_BIT_DEF,
   parameter int unsigned WAIT_MAX = WAIT_MAX_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              ack0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack1,
   output logic              err,
   input  logic              mem_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              dev_sel
);

   localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

   arb_state_t        state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_q, last_d;
   logic [7:0]        wait_cnt_q, wait_cnt_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              dev_sel_q, dev_sel_d;
   logic              ack0_q, ack0_d;
   logic              ack1_q, ack1_d;
   logic              err_q, err_d;

   logic              grant_valid;
   logic              grant_id;

   rr_pick2 u_pick (
      .req0        (req0),
      .req1        (req1),
      .last        (last_q),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      wait_cnt_d  = wait_cnt_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      dev_sel_d   = dev_sel_q;
      ack0_d      = 1'b0;
      ack1_d      = 1'b0;
      err_d       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (grant_valid) begin
               state_d     = GRANT;
               owner_d     = grant_id;
               last_d      = grant_id;
               wait_cnt_d  = 8'd0;
               mem_addr_d  = grant_id ? addr1 : addr0;
               mem_wdata_d = grant_id ? wdata1 : wdata0;
               dev_sel_d   = mem_addr_d[SEL_BIT];
            end
         end
         GRANT: begin
            // Ready in the last allowed cycle still counts as success.
            if (mem_ready || (wait_cnt_q == WAIT_LAST)) begin
               state_d = ACK;
               ack0_d  = ~owner_q;
               ack1_d  = owner_q;
               err_d   = ~mem_ready;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      mem_we_d = (state_d == GRANT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         last_q      <= 1'b1;
         wait_cnt_q  <= 8'd0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         dev_sel_q   <= 1'b0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         wait_cnt_q  <= wait_cnt_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         dev_sel_q   <= dev_sel_d;
         ack0_q      <= ack0_d;
         ack1_q      <= ack1_d;
         err_q       <= err_d;
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign dev_sel   = dev_sel_q;
   assign ack0      = ack0_q;
   assign ack1      = ack1_q;
   assign err       = err_q;

endmodule

// File: tb/tb_wr_port_arbiter.sv
// Self-checking bench for wr_port_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_wr_port_arbiter;

   localparam int ADDR_W   = 32;
   localparam int DATA_W   = 32;
   localparam int SEL_BIT  = 11;
   localparam int WAIT_MAX = 8;

   logic              clk;
   logic              reset;
   logic              req0, req1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              ack0, ack1, err;
   logic              mem_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              dev_sel;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_acks_seen = 0;
   int   n_excl = 0;
   logic m_last;

   wr_port_arbiter #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .SEL_BIT  (SEL_BIT),
      .WAIT_MAX (WAIT_MAX)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req0      (req0),
      .addr0     (addr0),
      .wdata0    (wdata0),
      .ack0      (ack0),
      .req1      (req1),
      .addr1     (addr1),
      .wdata1    (wdata1),
      .ack1      (ack1),
      .err       (err),
      .mem_ready (mem_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .dev_sel   (dev_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Mutual exclusion of acks and write strobe, watched on every cycle.
   always @(negedge clk) begin
      if (ack0 || ack1) n_acks_seen++;
      if ((ack0 && ack1) || ((ack0 || ack1) && mem_we)) n_excl++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req0 = 1'b0;
      req1 = 1'b0;
      mem_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      m_last = 1'b1;
      chk("rst_ctl", 64'({mem_we, ack0, ack1, err, dev_sel}), 64'd0);
      chk("rst_addr", 64'(mem_addr), 64'd0);
      chk("rst_data", 64'(mem_wdata), 64'd0);
   endtask

   // Start in IDLE, end in the next IDLE. stall = GRANT cycles with mem_ready low
   // before it rises; stall >= WAIT_MAX means the target never answers.
   task automatic do_txn(input logic r0, input logic r1, input int stall);
      logic              win;
      logic [ADDR_W-1:0] ea;
      logic [DATA_W-1:0] ed;
      logic              eerr;
      int                n;
      req0 = r0;
      req1 = r1;
      mem_ready = 1'($urandom);
      if (!r0 && !r1) begin
         tick();
         chk("idle_out", 64'({mem_we, ack0, ack1, err}), 64'd0);
         return;
      end
      win    = (r0 && r1) ? ~m_last : r1;
      m_last = win;
      ea     = win ? addr1 : addr0;
      ed     = win ? wdata1 : wdata0;
      n      = (stall < WAIT_MAX) ? stall + 1 : WAIT_MAX;
      eerr   = (stall >= WAIT_MAX);
      tick();
      for (int k = 0; k < n; k++) begin
         chk("grant_we", 64'(mem_we), 64'd1);
         chk("grant_addr", 64'(mem_addr), 64'(ea));
         chk("grant_data", 64'(mem_wdata), 64'(ed));
         chk("grant_sel", 64'(dev_sel), 64'(ea[SEL_BIT]));
         chk("grant_noack", 64'({ack0, ack1, err}), 64'd0);
         mem_ready = (k == stall);
         if ($urandom_range(0, 3) == 0) begin
            req0 = 1'b0;
            req1 = 1'b0;
         end
         tick();
      end
      chk("ack_owner", 64'({ack1, ack0}), win ? 64'd2 : 64'd1);
      chk("ack_err", 64'(err), 64'(eerr));
      chk("ack_we", 64'(mem_we), 64'd0);
      mem_ready = 1'($urandom);
      tick();
      chk("post_ack", 64'({mem_we, ack0, ack1, err}), 64'd0);
   endtask

   initial begin
      int base;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      do_reset();

      // Single write to memory space.
      addr0 = 32'h0000_0100;
      wdata0 = 32'hDEAD_BEEF;
      do_txn(1'b1, 1'b0, 0);

      // Tie immediately after reset: requester 0 first, then I/O write from 1.
      do_reset();
      addr0 = 32'h0000_0200;
      wdata0 = 32'h1111_2222;
      addr1 = 32'h0000_0800;
      wdata1 = 32'h3333_4444;
      do_txn(1'b1, 1'b1, 0);
      do_txn(1'b0, 1'b1, 0);
      chk("tie_io_sel", 64'(addr1[SEL_BIT]), 64'd1);

      // Sustained contention: strict alternation, four acks in twelve cycles.
      base = n_acks_seen;
      for (int i = 0; i < 4; i++) do_txn(1'b1, 1'b1, 0);
      chk("sustain_acks", 64'(n_acks_seen - base), 64'd4);

      // Stall, ready in the last allowed cycle, and timeout.
      do_txn(1'b1, 1'b0, 3);
      do_txn(1'b0, 1'b1, WAIT_MAX - 1);
      do_txn(1'b1, 1'b0, WAIT_MAX);
      do_txn(1'b0, 1'b1, WAIT_MAX + 5);

      // No requests: mem_ready alone must not start anything.
      req0 = 1'b0; req1 = 1'b0; mem_ready = 1'b1;
      tick();
      tick();
      chk("idle_ready", 64'({mem_we, ack0, ack1, err}), 64'd0);

      // Reset during the second stalled GRANT cycle.
      req0 = 1'b1; req1 = 1'b0; mem_ready = 1'b0;
      tick();
      chk("mid_we1", 64'(mem_we), 64'd1);
      tick();
      chk("mid_we2", 64'(mem_we), 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_last = 1'b1;
      chk("mid_rst", 64'({mem_we, ack0, ack1, err}), 64'd0);
      req0 = 1'b0;
      tick();
      chk("mid_quiet", 64'({mem_we, ack0, ack1, err}), 64'd0);
      do_txn(1'b1, 1'b1, 0);

      // Randomized traffic.
      for (int i = 0; i < 60; i++) begin
         addr0  = $urandom;
         addr1  = $urandom;
         wdata0 = $urandom;
         wdata1 = $urandom;
         do_txn(1'($urandom), 1'($urandom), int'($urandom_range(0, WAIT_MAX + 2)));
      end

      chk("exclusive", 64'(n_excl), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
